// File: rtl/lamp_tay_mul_arbiter.sv
// lamp_tay_mul_arbiter
// Shares one Taylor-stage multiplier (lampFPU_TAY_mul, 1-cycle latency) among
// NUM_REQ requesters of the bfloat16 exponential datapath. Eligible requesters
// are granted one per cycle. The granted operands are registered into the
// multiplier, and the ownership tag travels alongside the operation. Each
// result lands in a single-entry response buffer per requester.
//
// Handshakes: a request transfers when req_valid_i[i] & req_ready_o[i]; the
// requester holds valid and operands stable until then. A response transfers
// when resp_valid_o[i] & resp_ready_i[i]; the buffer holds its data until then.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req_valid_i/ready_o  per-requester request handshake (ready one-hot or 0)
//   req_op1_i/op2_i   packed operands, requester i at [i*OP_W +: OP_W]
//   resp_valid_o/ready_i per-requester response handshake
//   resp_data_o       buffered results, requester i at [i*RES_W +: RES_W]
//   mul_do_o, mul_op1_o, mul_op2_o  issue to multiplier
//   mul_valid_i, mul_res_i          multiplier result
//   err_o             sticky: mul_valid_i disagreed with the expected slot
//
// Build option: define LAMP_TAY_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no round-robin pointer); default build is round-robin.
module lamp_tay_mul_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int OP_W    = 25,
    parameter int RES_W   = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*OP_W-1:0]  req_op1_i,
    input  logic [NUM_REQ*OP_W-1:0]  req_op2_i,
    output logic [NUM_REQ-1:0]       resp_valid_o,
    input  logic [NUM_REQ-1:0]       resp_ready_i,
    output logic [NUM_REQ*RES_W-1:0] resp_data_o,
    output logic                     mul_do_o,
    output logic [OP_W-1:0]          mul_op1_o,
    output logic [OP_W-1:0]          mul_op2_o,
    input  logic                     mul_valid_i,
    input  logic [RES_W-1:0]         mul_res_i,
    output logic                     err_o
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       pend_q, pend_d;
    logic [NUM_REQ-1:0]       resp_vld_q, resp_vld_d;
    logic [NUM_REQ*RES_W-1:0] buf_q, buf_d;
    logic                     s1_vld_q, s1_vld_d;
    logic [TAG_W-1:0]         s1_tag_q, s1_tag_d;
    logic [OP_W-1:0]          op1_q, op1_d;
    logic [OP_W-1:0]          op2_q, op2_d;
    logic                     s2_vld_q, s2_vld_d;
    logic [TAG_W-1:0]         s2_tag_q, s2_tag_d;
    logic                     err_q, err_d;
    // High only in the first cycle after reset: a result still draining out
    // of the multiplier from before reset is dropped without flagging.
    logic                     post_rst_q, post_rst_d;

    logic [NUM_REQ-1:0]       elig;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       resp_hs;
    logic                     grant_any;
    logic [TAG_W-1:0]         grant_idx;
    logic                     wb_en;

`ifndef LAMP_TAY_ARB_FIXED_PRIO_EN
    logic [TAG_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [TAG_W:0]           cand;
`endif

    // Arbiter. Both variants scan from lowest to highest priority, so the
    // last hit (the highest priority) wins.
    always_comb begin
        elig      = req_valid_i & ~pend_q;
        grant_any = 1'b0;
        grant_idx = '0;
`ifdef LAMP_TAY_ARB_FIXED_PRIO_EN
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (elig[k]) begin
                grant_any = 1'b1;
                grant_idx = TAG_W'(k);
            end
        end
`else
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (TAG_W+1)'(k);
            if (cand >= (TAG_W+1)'(NUM_REQ)) begin
                cand = cand - (TAG_W+1)'(NUM_REQ);
            end
            if (elig[cand[TAG_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[TAG_W-1:0];
            end
        end
`endif
        grant = '0;
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        resp_hs    = resp_vld_q & resp_ready_i;
        // A grant and a handshake never hit the same requester: a granted
        // requester was not pending, so its buffer was empty.
        pend_d     = (pend_q & ~resp_hs) | grant;
        resp_vld_d = resp_vld_q & ~resp_hs;
        buf_d      = buf_q;

        s1_vld_d   = grant_any;
        s1_tag_d   = s1_tag_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        if (grant_any) begin
            s1_tag_d = grant_idx;
            op1_d    = req_op1_i[int'(grant_idx)*OP_W +: OP_W];
            op2_d    = req_op2_i[int'(grant_idx)*OP_W +: OP_W];
        end

        s2_vld_d   = s1_vld_q;
        s2_tag_d   = s1_tag_q;

        // A spurious mul_valid_i (no operation in the slot) writes nothing.
        wb_en = s2_vld_q & mul_valid_i;
        if (wb_en) begin
            buf_d[int'(s2_tag_q)*RES_W +: RES_W] = mul_res_i;
            resp_vld_d[s2_tag_q]                 = 1'b1;
        end

        err_d      = err_q | (~post_rst_q & (mul_valid_i ^ s2_vld_q));
        post_rst_d = 1'b0;

`ifndef LAMP_TAY_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            resp_vld_q <= '0;
            buf_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_tag_q   <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            s2_vld_q   <= 1'b0;
            s2_tag_q   <= '0;
            err_q      <= 1'b0;
            post_rst_q <= 1'b1;
`ifndef LAMP_TAY_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            pend_q     <= pend_d;
            resp_vld_q <= resp_vld_d;
            buf_q      <= buf_d;
            s1_vld_q   <= s1_vld_d;
            s1_tag_q   <= s1_tag_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            s2_vld_q   <= s2_vld_d;
            s2_tag_q   <= s2_tag_d;
            err_q      <= err_d;
            post_rst_q <= post_rst_d;
`ifndef LAMP_TAY_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign req_ready_o  = grant;
    assign resp_valid_o = resp_vld_q;
    assign resp_data_o  = buf_q;
    assign mul_do_o     = s1_vld_q;
    assign mul_op1_o    = op1_q;
    assign mul_op2_o    = op2_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_lamp_tay_mul_arbiter.sv
// Bench for lamp_tay_mul_arbiter: a stand-in 1-cycle multiplier, a
// transaction-level model (issued operations tagged with their issue cycle),
// a per-cycle compare process, and directed scenarios with literal checks.
module tb_lamp_tay_mul_arbiter;

    localparam int N  = 3;
    localparam int OW = 25;
    localparam int RW = 24;
    localparam logic [OW-1:0] ONE = 25'h0803F80;  // s=0 extShF=0x80 extE=127

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*OW-1:0] req_op1 = '0;
    logic [N*OW-1:0] req_op2 = '0;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready = '0;
    logic [N*RW-1:0] resp_data;
    logic            mul_do;
    logic [OW-1:0]   mul_op1, mul_op2;
    logic            mul_valid;
    logic            mul_vq = 1'b0;
    logic            spur = 1'b0;
    logic [RW-1:0]   mul_res = '0;
    logic            err;

    int total = 0;
    int bad   = 0;

    lamp_tay_mul_arbiter #(.NUM_REQ(N), .OP_W(OW), .RES_W(RW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op1_i(req_op1), .req_op2_i(req_op2),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
        .mul_do_o(mul_do), .mul_op1_o(mul_op1), .mul_op2_o(mul_op2),
        .mul_valid_i(mul_valid), .mul_res_i(mul_res), .err_o(err)
    );

    // Stand-in multiplier: s = s1^s2, e = e1+e2-127, f = top 12 bits of the
    // 8x8 significand product, flags 0.
    function automatic logic [RW-1:0] mul_fn(input logic [OW-1:0] a, input logic [OW-1:0] b);
        logic [15:0] p;
        logic [8:0]  e;
        p = 16'(a[23:16]) * 16'(b[23:16]);
        e = a[15:7] + b[15:7] - 9'd127;
        return {a[24] ^ b[24], e[7:0], p[15:4], 3'b000};
    endfunction

    always @(posedge clk) begin
        mul_vq  <= mul_do;
        mul_res <= mul_fn(mul_op1, mul_op2);
    end
    assign mul_valid = mul_vq | spur;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model + per-cycle compare ----------------
    logic [N-1:0]  pend_m, resp_v_m;
    logic [RW-1:0] buf_m[N];
    logic [OW-1:0] lop1_m, lop2_m;
    logic          err_m;
    int            rr_m;
    bit            first_m;
    int            cyc;
    int            rec_cyc[$];
    int            rec_tag[$];
    logic [RW-1:0] exp_q[$];

    task automatic model_reset();
        pend_m = '0; resp_v_m = '0; lop1_m = '0; lop2_m = '0;
        err_m = 1'b0; rr_m = 0; first_m = 1'b1;
        for (int i = 0; i < N; i++) buf_m[i] = '0;
        rec_cyc.delete(); rec_tag.delete(); exp_q.delete();
    endtask

    initial begin
        logic [N-1:0]    elig, exp_rdy, hs;
        logic [N*RW-1:0] buf_flat;
        int              eg, idx, j2;
        bit              exp_do;
        cyc = 0;
        model_reset();
        @(posedge clk);
        forever begin
            @(negedge clk);
            elig = req_valid & ~pend_m;
            eg = -1;
            for (int k = 0; k < N; k++) begin
`ifdef LAMP_TAY_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (rr_m + k) % N;
`endif
                if (eg < 0 && elig[idx]) eg = idx;
            end
            exp_rdy = '0;
            if (eg >= 0) exp_rdy[eg] = 1'b1;
            exp_do = 1'b0;
            j2 = -1;
            for (int j = 0; j < rec_cyc.size(); j++) begin
                if (rec_cyc[j] == cyc - 1) exp_do = 1'b1;
                if (rec_cyc[j] == cyc - 2) j2 = j;
            end
            for (int i = 0; i < N; i++) buf_flat[i*RW +: RW] = buf_m[i];

            check("req_ready", 128'(req_ready), 128'(exp_rdy));
            check("mul_do", 128'(mul_do), 128'(exp_do));
            check("mul_op1", 128'(mul_op1), 128'(lop1_m));
            check("mul_op2", 128'(mul_op2), 128'(lop2_m));
            check("resp_valid", 128'(resp_valid), 128'(resp_v_m));
            check("resp_data", 128'(resp_data), 128'(buf_flat));
            check("err", 128'(err), 128'(err_m));

            if (rst) begin
                model_reset();
            end else begin
                if (!first_m && (mul_valid !== (j2 >= 0))) err_m = 1'b1;
                hs = resp_v_m & resp_ready;
                resp_v_m = resp_v_m & ~hs;
                pend_m   = pend_m & ~hs;
                if (j2 >= 0 && mul_valid === 1'b1) begin
                    resp_v_m[rec_tag[j2]] = 1'b1;
                    buf_m[rec_tag[j2]]    = exp_q[j2];
                end
                while (rec_cyc.size() > 0 && rec_cyc[0] <= cyc - 2) begin
                    void'(rec_cyc.pop_front());
                    void'(rec_tag.pop_front());
                    void'(exp_q.pop_front());
                end
                if (eg >= 0) begin
                    pend_m[eg] = 1'b1;
                    rr_m = (eg + 1) % N;
                    lop1_m = req_op1[eg*OW +: OW];
                    lop2_m = req_op2[eg*OW +: OW];
                    rec_cyc.push_back(cyc);
                    rec_tag.push_back(eg);
                    exp_q.push_back(mul_fn(lop1_m, lop2_m));
                end
                first_m = 1'b0;
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    // Ends at posedge+1 of the first cycle after reset.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; spur = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic logic [OW-1:0] rand_op();
        logic [OW-1:0] o;
        o = '0;
        o[24]    = 1'($urandom_range(0, 1));
        o[23:16] = 8'($urandom_range(128, 255));
        o[15:7]  = 9'($urandom_range(100, 150));
        return o;
    endfunction

    initial begin
        logic [N-1:0]  cont_exp[9];
        logic [RW-1:0] exp1;
        int g0, g1, g2;
        cont_exp[0] = 3'b001; cont_exp[1] = 3'b010; cont_exp[2] = 3'b100;
        cont_exp[3] = 3'b000; cont_exp[4] = 3'b001; cont_exp[5] = 3'b010;
        cont_exp[6] = 3'b100; cont_exp[7] = 3'b000; cont_exp[8] = 3'b001;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 128'(req_ready), 128'(0));
        check("rst_resp_valid", 128'(resp_valid), 128'(0));
        check("rst_resp_data", 128'(resp_data), 128'(0));
        check("rst_mul_do", 128'(mul_do), 128'(0));
        check("rst_mul_op1", 128'(mul_op1), 128'(0));
        check("rst_err", 128'(err), 128'(0));

        // Single request, 1.0 * 1.0
        @(posedge clk); #1;
        req_op1[0 +: OW] = ONE; req_op2[0 +: OW] = ONE;
        req_valid = 3'b001; resp_ready = 3'b111;
        @(negedge clk);
        check("single_grant_T", 128'(req_ready), 128'(3'b001));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("single_do_T1", 128'(mul_do), 128'(1));
        check("single_op_T1", 128'(mul_op1), 128'(ONE));
        @(negedge clk);
        check("single_rv_T2", 128'(resp_valid), 128'(0));
        @(negedge clk);
        check("single_rv_T3", 128'(resp_valid), 128'(3'b001));
        check("single_data_T3", 128'(resp_data[0 +: RW]), 128'(24'h3FA000));
        repeat (2) @(posedge clk);

        // Full contention for 9 cycles
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_op1[i*OW +: OW] = rand_op();
            req_op2[i*OW +: OW] = rand_op();
        end
        req_valid = 3'b111; resp_ready = 3'b111;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check($sformatf("contention_c%0d", c), 128'(req_ready), 128'(cont_exp[c]));
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (4) @(posedge clk);

        // Backpressure on requester 1 for 10 cycles
        do_reset();
        req_op1[OW +: OW] = rand_op();
        req_op2[OW +: OW] = rand_op();
        exp1 = mul_fn(req_op1[OW +: OW], req_op2[OW +: OW]);
        req_valid = 3'b111; resp_ready = 3'b101;
        g0 = 0; g1 = 0; g2 = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready[0]) g0++;
            if (req_ready[1]) g1++;
            if (req_ready[2]) g2++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bp_grants0", 128'(g0), 128'(3));
        check("bp_grants1", 128'(g1), 128'(1));
        check("bp_grants2", 128'(g2), 128'(2));
        check("bp_rv1_held", 128'(resp_valid[1]), 128'(1));
        check("bp_data1_held", 128'(resp_data[RW +: RW]), 128'(exp1));
        @(posedge clk); #1;
        req_valid = '0; resp_ready = 3'b111;
        repeat (5) @(posedge clk);

        // Spurious multiplier result
        do_reset();
        @(posedge clk); #1;
        spur = 1'b1;
        @(negedge clk);
        check("spur_err_same_cycle", 128'(err), 128'(0));
        @(posedge clk); #1;
        spur = 1'b0;
        @(negedge clk);
        check("spur_err_next", 128'(err), 128'(1));
        check("spur_no_write", 128'(resp_valid), 128'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("spur_err_sticky", 128'(err), 128'(1));
        do_reset();
        @(negedge clk);
        check("spur_err_cleared", 128'(err), 128'(0));

        // Reset with two operations in flight
        @(posedge clk); #1;
        req_op1[0 +: OW] = ONE; req_op2[0 +: OW] = ONE;
        req_op1[OW +: OW] = ONE; req_op2[OW +: OW] = ONE;
        req_valid = 3'b011; resp_ready = 3'b111;
        @(negedge clk);
        check("flight_g0", 128'(req_ready), 128'(3'b001));
        @(posedge clk); #1;
        @(negedge clk);
        check("flight_g1", 128'(req_ready), 128'(3'b010));
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("flight_do", 128'(mul_do), 128'(0));
        check("flight_op1", 128'(mul_op1), 128'(0));
        check("flight_rv", 128'(resp_valid), 128'(0));
        check("flight_data", 128'(resp_data), 128'(0));
        check("flight_err", 128'(err), 128'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("flight_rv_late", 128'(resp_valid), 128'(0));
        check("flight_err_late", 128'(err), 128'(0));

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lamp_tay_mul_arbiter.md
# lamp_tay_mul_arbiter

- Shares one Taylor-stage multiplier (`lampFPU_TAY_mul`) among `NUM_REQ` requesters in the bfloat16 exponential datapath, e.g. power generator, coefficient scaler and range-reduction step.
- Arbitrates per-cycle issue, registers operands into the multiplier, tracks in-flight ownership by tag, and routes each result into a per-requester single-entry response buffer with valid/ready handshake.

## Interface

Parameters:
- `NUM_REQ`, default 3: number of requesters, 2..8.
- `OP_W`, default 25: packed unpacked-operand bundle `{s, extShF[7:0], extE[8:0], nlz[2:0], isZ, isInf, isSNAN, isQNAN}`.
- `RES_W`, default 24: packed result bundle `{s, e[7:0], f[11:0], isOverflow, isUnderflow, isToRound}`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid_i` in `NUM_REQ`: request pending, one bit per requester.
- `req_ready_o` out `NUM_REQ`: grant; one-hot or zero.
- `req_op1_i` in `NUM_REQ*OP_W`: operand 1, requester i at slice `[i*OP_W +: OP_W]`.
- `req_op2_i` in `NUM_REQ*OP_W`: operand 2, same slicing.
- `resp_valid_o` out `NUM_REQ`: result available.
- `resp_ready_i` in `NUM_REQ`: result consumed.
- `resp_data_o` out `NUM_REQ*RES_W`: result, requester i at slice `[i*RES_W +: RES_W]`.
- `mul_do_o` out 1: drives multiplier `doMul_i`.
- `mul_op1_o` out `OP_W`: unpacked fields to multiplier op1.
- `mul_op2_o` out `OP_W`: unpacked fields to multiplier op2.
- `mul_valid_i` in 1: multiplier `valid_o`.
- `mul_res_i` in `RES_W`: packed multiplier outputs.
- `err_o` out 1: sticky protocol error.

## Operation

- **Eligibility:** `elig[i] = req_valid_i[i] & ~pend[i]`.
  - `pend[i]` is registered: set on grant, cleared on the response handshake `resp_valid_o[i] & resp_ready_i[i]`.
  - At most one operation per requester is outstanding.
- **Arbitration:** round-robin over `elig` starting at `rr_ptr`.
  - On a grant to i, `rr_ptr <= (i+1) mod NUM_REQ`.
  - `req_ready_o` is combinational from `elig` and `rr_ptr`.
  - A requester holds valid and operands stable until ready.
- **Issue stage:** on grant, latch op1/op2 into issue registers and set `s1_vld = 1`, `s1_tag = i`.
  - `mul_do_o = s1_vld`.
  - `mul_op*_o` come from the issue registers, which hold their value when no grant occurs.
- **Multiplier stage:** `s2_vld <= s1_vld`, `s2_tag <= s1_tag`.
  - The multiplier has 1-cycle latency, so `mul_valid_i` must equal `s2_vld`.
- **Writeback:** when `s2_vld & mul_valid_i`, write `mul_res_i` to `buf[s2_tag]` and set `resp_valid_o[s2_tag]`.
  - The buffer cannot be occupied at this point, because `pend` guarantees it.
- **Error:** `err_o` sets and stays set until `rst` when `mul_valid_i != s2_vld`.
  - A spurious `mul_valid_i` (high with `s2_vld` low) is not written to any buffer.
  - A missing `mul_valid_i` (low with `s2_vld` high) leaves `pend[s2_tag]` stuck.
- **Boundaries:**
  - A handshake clearing `pend[i]` takes effect the next cycle; i cannot be granted in the same cycle.
  - With all requesters pending or invalid, no grant occurs and `mul_do_o = 0`.
  - `rst` mid-operation discards the issue stage, multiplier stage and buffer contents.
  - A `mul_valid_i` in the first cycle after `rst` is ignored and raises no error.

## Timing

Reset values:
- `req_ready_o` = 0 (combinational; 0 because `pend = 0`, `req_valid_i` low).
- `resp_valid_o` = 0, `resp_data_o` = 0.
- `mul_do_o` = 0, `mul_op*_o` = 0.
- `err_o` = 0, `rr_ptr` = 0.

Latency and throughput:
- Accept in cycle T → `mul_do_o` in T+1 → `mul_valid_i` in T+2 → `resp_valid_o` in T+3.
- Aggregate throughput is one issue per cycle.
- Per-requester issue interval is at least 4 cycles: response at T+3, consumed at T+3, regrant at T+4.

## Configuration

- `LAMP_TAY_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins; `rr_ptr` is not implemented.
- Undefined (default): round-robin as specified above.

## Test plan

- **Single request:** req0 with op1 = op2 = 1.0, i.e. `extShF = 0x80`, `extE = 127`.
  - `mul_do_o` at T+1.
  - `resp_valid_o[0]` at T+3 with `e = 127`, `f = 0x400`, other bits 0.
- **Full contention:** all 3 requesters valid for 9 cycles, `resp_ready_i = 1`.
  - Grant order 0,1,2,0,1,2.
  - Each requester is regranted at exactly the 4-cycle minimum.
  - With `FIXED_PRIO_EN`: 0,1,2, then 0 again as soon as eligible.
- **Backpressure:** `resp_ready_i[1]` held 0 for 10 cycles.
  - Requester 1 is never regranted.
  - `resp_data_o[1]` stays stable.
  - The other requesters keep full service.
- **Spurious result:** `mul_valid_i` forced high with `s2_vld = 0`.
  - `err_o = 1` next cycle, no buffer written.
  - `err_o` holds until `rst`.
- **Reset with two operations in flight:** all outputs return to their reset values next cycle.
  - The late `mul_valid_i` is ignored.
  - `err_o` stays 0.
